mem_arbiter: RTL

Shares the single byte-serial RAM engine between the instruction fetch path (icache miss) and the MEM stage (load/store).
- Sits between icache/MEM and mem_ctrl.
- Decides which requester owns the engine and latches the winning request.
- Squashes in-flight fetches on jump and routes the completion back.
- Data requests have priority; a streak limiter prevents fetch starvation.

---
 rtl/mem_arbiter_pkg.sv | 30 +++
 rtl/mem_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared encodings for the memory arbiter.
//               Holds the access-width codes, the arbiter state encoding and
//               a helper that tells whether a width code can be issued to
//               the byte-serial engine.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Access width codes (one-hot byte count)
  localparam logic [2:0] WIDTH_B = 3'b001;
  localparam logic [2:0] WIDTH_H = 3'b010;
  localparam logic [2:0] WIDTH_W = 3'b100;

  // Arbiter state encoding
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  // Only byte, half and word accesses are issued to the engine.
  function automatic logic width_legal(input logic [2:0] w);
    return (w == WIDTH_B) || (w == WIDTH_H) || (w == WIDTH_W);
  endfunction

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the byte-serial RAM engine between instruction fetch
//               and the MEM stage. Data requests win unless a fetch has
//               waited through STREAK_MAX data grants. Fetches are squashed
//               on pipeline redirect.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               is_jump          - redirect, kills pending/in-flight fetch
//               if_*             - fetch request / completion
//               mem_*            - load/store request / completion
//               ctl_*            - request to and completion from engine
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_jump,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_rdy,
  output logic [DATA_W-1:0] if_data,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_width,
  input  logic              mem_rw,
  output logic              mem_rdy,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              ctl_valid,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  output logic [2:0]        ctl_width,
  output logic              ctl_rw,
  input  logic              ctl_done,
  input  logic [DATA_W-1:0] ctl_rdata
);

  localparam logic [3:0] c_STREAK_MAX = 4'(STREAK_MAX);

  arb_state_t        r_state,     w_state_nxt;
  logic [3:0]        r_streak,    w_streak_nxt;
  logic              r_squash,    w_squash_nxt;
  logic              r_if_rdy,    w_if_rdy_nxt;
  logic [DATA_W-1:0] r_if_data,   w_if_data_nxt;
  logic              r_mem_rdy,   w_mem_rdy_nxt;
  logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata_nxt;
  logic              r_ctl_valid, w_ctl_valid_nxt;
  logic [ADDR_W-1:0] r_ctl_addr,  w_ctl_addr_nxt;
  logic [DATA_W-1:0] r_ctl_wdata, w_ctl_wdata_nxt;
  logic [2:0]        r_ctl_width, w_ctl_width_nxt;
  logic              r_ctl_rw,    w_ctl_rw_nxt;

  logic w_if_elig, w_mem_elig, w_grant_i, w_grant_d;

  // Zero-extend engine read data to the access width.
  function automatic logic [DATA_W-1:0] mask_rdata(input logic [DATA_W-1:0] d,
                                                   input logic [2:0]        w);
    case (w)
      WIDTH_B: mask_rdata = {{(DATA_W-8){1'b0}}, d[7:0]};
      WIDTH_H: mask_rdata = {{(DATA_W-16){1'b0}}, d[15:0]};
      default: mask_rdata = d;
    endcase
  endfunction

  // A requester sitting in its rdy cycle is still holding the request it
  // just completed, so it must not be granted again that cycle.
  assign w_if_elig  = if_req  && !r_if_rdy && !is_jump;
  assign w_mem_elig = mem_req && !r_mem_rdy;
  assign w_grant_i  = (r_state == ARB_IDLE) && w_if_elig &&
                      (!w_mem_elig || (r_streak == c_STREAK_MAX));
  assign w_grant_d  = (r_state == ARB_IDLE) && w_mem_elig && !w_grant_i;

  always_comb begin
    w_state_nxt     = r_state;
    w_squash_nxt    = r_squash;
    w_if_rdy_nxt    = 1'b0;
    w_if_data_nxt   = r_if_data;
    w_mem_rdy_nxt   = 1'b0;
    w_mem_rdata_nxt = r_mem_rdata;
    w_ctl_valid_nxt = r_ctl_valid;
    w_ctl_addr_nxt  = r_ctl_addr;
    w_ctl_wdata_nxt = r_ctl_wdata;
    w_ctl_width_nxt = r_ctl_width;
    w_ctl_rw_nxt    = r_ctl_rw;

    case (r_state)
      ARB_IDLE: begin
        if (w_grant_i) begin
          w_ctl_valid_nxt = 1'b1;
          w_ctl_addr_nxt  = if_addr;
          w_ctl_wdata_nxt = '0;
          w_ctl_width_nxt = WIDTH_W;
          w_ctl_rw_nxt    = 1'b1;
          w_squash_nxt    = 1'b0;
          w_state_nxt     = ARB_BUSY_I;
        end else if (w_grant_d) begin
          if (width_legal(mem_width)) begin
            w_ctl_valid_nxt = 1'b1;
            w_ctl_addr_nxt  = mem_addr;
            w_ctl_wdata_nxt = mem_wdata;
            w_ctl_width_nxt = mem_width;
            w_ctl_rw_nxt    = mem_rw;
            w_state_nxt     = ARB_BUSY_D;
          end else begin
            // Illegal width: answer immediately without touching the engine.
            w_mem_rdy_nxt   = 1'b1;
            w_mem_rdata_nxt = '0;
          end
        end
      end

      ARB_BUSY_I: begin
        if (is_jump) begin
          w_squash_nxt = 1'b1;
        end
        if (ctl_done) begin
          w_ctl_valid_nxt = 1'b0;
          w_state_nxt     = ARB_IDLE;
          w_squash_nxt    = 1'b0;
          // A jump on the done cycle itself also kills the result.
          if (!r_squash && !is_jump) begin
            w_if_rdy_nxt  = 1'b1;
            w_if_data_nxt = ctl_rdata;
          end
        end
      end

      ARB_BUSY_D: begin
        if (ctl_done) begin
          w_ctl_valid_nxt = 1'b0;
          w_mem_rdy_nxt   = 1'b1;
          w_mem_rdata_nxt = r_ctl_rw ? mask_rdata(ctl_rdata, r_ctl_width) : '0;
          w_state_nxt     = ARB_IDLE;
        end
      end

      default: begin
        w_state_nxt     = ARB_IDLE;
        w_ctl_valid_nxt = 1'b0;
      end
    endcase
  end

  // Streak counts data grants that overtook a waiting fetch.
  always_comb begin
    w_streak_nxt = r_streak;
    if (!if_req || w_grant_i) begin
      w_streak_nxt = '0;
    end else if (w_grant_d && (r_streak < c_STREAK_MAX)) begin
      w_streak_nxt = r_streak + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ARB_IDLE;
      r_streak    <= '0;
      r_squash    <= 1'b0;
      r_if_rdy    <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdy   <= 1'b0;
      r_mem_rdata <= '0;
      r_ctl_valid <= 1'b0;
      r_ctl_addr  <= '0;
      r_ctl_wdata <= '0;
      r_ctl_width <= '0;
      r_ctl_rw    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_streak    <= w_streak_nxt;
      r_squash    <= w_squash_nxt;
      r_if_rdy    <= w_if_rdy_nxt;
      r_if_data   <= w_if_data_nxt;
      r_mem_rdy   <= w_mem_rdy_nxt;
      r_mem_rdata <= w_mem_rdata_nxt;
      r_ctl_valid <= w_ctl_valid_nxt;
      r_ctl_addr  <= w_ctl_addr_nxt;
      r_ctl_wdata <= w_ctl_wdata_nxt;
      r_ctl_width <= w_ctl_width_nxt;
      r_ctl_rw    <= w_ctl_rw_nxt;
    end
  end

  assign if_rdy    = r_if_rdy;
  assign if_data   = r_if_data;
  assign mem_rdy   = r_mem_rdy;
  assign mem_rdata = r_mem_rdata;
  assign ctl_valid = r_ctl_valid;
  assign ctl_addr  = r_ctl_addr;
  assign ctl_wdata = r_ctl_wdata;
  assign ctl_width = r_ctl_width;
  assign ctl_rw    = r_ctl_rw;

endmodule : mem_arbiter
`default_nettype wire
